gcd_dispatch: RTL and testbench
===============================

# gcd_dispatch

Upstream operand dispatcher for the `gcd` core. It accepts operand pairs over a ready/valid stream and buffers them in a small FIFO. It issues each pair to the core as the core's single-cycle `valid_i` pulse, waits for the core's `valid_o`, and presents the result with its operands on a ready/valid output stream. The `gcd` core has no backpressure of its own; this block is the only path by which the system feeds it.

## Interface
Parameters:
- WIDTH, 8: operand and result width; must match the attached `gcd` core.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk_i, in, 1: single clock.
- reset_i, in, 1: asynchronous, active-high reset. The same net also resets the `gcd` core.
- in_valid_i, in, 1: input pair valid.
- in_ready_o, out, 1: FIFO not full.
- in_a_i, in, WIDTH: operand A.
- in_b_i, in, WIDTH: operand B.
- core_valid_o, out, 1: drives the core's `valid_i`.
- core_a_o, out, WIDTH: drives the core's `a_i`.
- core_b_o, out, WIDTH: drives the core's `b_i`.
- core_done_i, in, 1: from the core's `valid_o`.
- core_gcd_i, in, WIDTH: from the core's `gcd_o`.
- out_valid_o, out, 1: result valid.
- out_ready_i, in, 1: consumer ready.
- out_a_o, out, WIDTH: operand A of the result.
- out_b_o, out, WIDTH: operand B of the result.
- out_gcd_o, out, WIDTH: GCD result.
- count_o, out, $clog2(DEPTH)+1: FIFO occupancy.

## Operation
FIFO:
- Push occurs when in_valid_i && in_ready_o.
- in_ready_o = (count < DEPTH), computed from the registered count only. A pop in the same cycle does not open a slot, so a full FIFO refuses a push even when it is popping.
- Push and pop in the same cycle leave count unchanged.
- There is no fall-through: a pushed entry is visible to the FSM on the following cycle.
- Pointers wrap modulo DEPTH.

FSM states IDLE, ISSUE, WAIT, HOLD:
- IDLE: if count > 0, go to ISSUE and load core_a_o/core_b_o from the FIFO head.
- ISSUE: core_valid_o = 1 for exactly this one cycle. Pop the head into the in-flight operand registers, then go to WAIT.
- WAIT: a registered copy of core_done_i, done_q, is kept in every state.
  - Capture when core_done_i && !done_q (rising edge).
  - On capture, load out_gcd_o ← core_gcd_i and out_a_o/out_b_o ← the in-flight operands, then go to HOLD.
  - A level-high core_done_i that persists or arrives outside WAIT is never captured.
- HOLD: out_valid_o = 1. On out_valid_o && out_ready_i, go to ISSUE if count > 0, otherwise go to IDLE.

Other rules:
- core_a_o/core_b_o are 0 in every state except ISSUE.
- The core's result is passed through unmodified; the block does no arithmetic and does not check the result.
- Exactly one operation is in flight at a time, and results leave in push order.

## Timing
- Reset values: in_ready_o=1, core_valid_o=0, core_a_o=0, core_b_o=0, out_valid_o=0, out_a_o=0, out_b_o=0, out_gcd_o=0, count_o=0. State is IDLE, done_q=0, and the FIFO pointers are 0.
- A push accepted at edge E0 into an empty, idle block:
  - State is ISSUE after E1, so core_valid_o is high in cycle E1–E2.
  - State is WAIT after E2.
- A core_done_i rising edge sampled at edge Ek gives out_valid_o=1 from Ek onward.
- HOLD→ISSUE is back-to-back: the next core_valid_o is high in the cycle immediately after the output handshake.
- The output fields are stable while out_valid_o=1 and out_ready_i=0.
- Reset asserted mid-operation (any state):
  - All outputs return to their reset values immediately.
  - FIFO contents and the in-flight pair are discarded.
  - After deassertion the block sits in IDLE with count 0.

## Test plan
- Single pair: push (48,18), out_ready_i=1 → exactly one core_valid_o pulse carrying a=48, b=18. Then out_valid_o with out_a_o=48, out_b_o=18, out_gcd_o=6. count_o returns to 0.
- Ordering and backpressure (DEPTH=4), out_ready_i=0: push (60,84),(17,23),(100,75),(128,64),(7,13),(255,255).
  - 5 pushes are accepted; in_ready_o goes low with count_o=4.
  - (255,255) is only accepted after the first output handshake.
  - Releasing out_ready_i yields results 12,1,25,64,1,255 in push order.
- Boundary operands: push (0,5) then (0,0) → out_gcd_o=5, then out_gcd_o=0, with operands echoed.
- Sticky done: a core model that holds core_done_i high for 5 cycles → exactly one capture and one output handshake. The next pair is not falsely completed by the still-high done.
- Reset mid-WAIT: pulse reset_i while an operation is in flight with 2 entries queued → all outputs reset asynchronously and count_o=0. No out_valid_o until a new push. A new pair (48,18) then completes with 6.
- Push/pop collision: with count_o=3 during ISSUE, push → count_o stays 3 and in_ready_o stays 1. With count_o=4 during ISSUE, a push is refused.

Source files
------------

// File: rtl/gcd_dispatch.sv
// Operand dispatcher for the gcd core: buffers operand pairs in a FIFO, issues one
// pair at a time as a single-cycle pulse, and returns each result with its operands.
module gcd_dispatch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WIDTH-1:0]         in_a_i,
    input  logic [WIDTH-1:0]         in_b_i,
    output logic                     core_valid_o,
    output logic [WIDTH-1:0]         core_a_o,
    output logic [WIDTH-1:0]         core_b_o,
    input  logic                     core_done_i,
    input  logic [WIDTH-1:0]         core_gcd_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         out_a_o,
    output logic [WIDTH-1:0]         out_b_o,
    output logic [WIDTH-1:0]         out_gcd_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are
    // both high; valid never waits on ready, and payload is held while valid && !ready.

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic             done_q;
    logic [WIDTH-1:0] fl_a_q, fl_b_q;
    logic [WIDTH-1:0] out_a_q, out_b_q, out_gcd_q;

    logic push, pop, capture;
    logic [WIDTH-1:0] head_a, head_b;

    assign head_a     = mem_a_q[rd_ptr_q];
    assign head_b     = mem_b_q[rd_ptr_q];
    // Registered count only, so a full FIFO stays closed even in the cycle it pops.
    assign in_ready_o = (count_q < CW'(DEPTH));
    assign push       = in_valid_i && in_ready_o;
    assign pop        = (state_q == S_ISSUE);
    assign capture    = (state_q == S_WAIT) && core_done_i && !done_q;

    assign core_valid_o = (state_q == S_ISSUE);
    assign core_a_o     = (state_q == S_ISSUE) ? head_a : '0;
    assign core_b_o     = (state_q == S_ISSUE) ? head_b : '0;
    assign out_valid_o  = (state_q == S_HOLD);
    assign out_a_o      = out_a_q;
    assign out_b_o      = out_b_q;
    assign out_gcd_o    = out_gcd_q;
    assign count_o      = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (capture) state_d = S_HOLD;
            S_HOLD:  if (out_ready_i) state_d = (count_q != '0) ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a_i;
            mem_b_q[wr_ptr_q] <= in_b_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            fl_a_q    <= '0;
            fl_b_q    <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            out_gcd_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            done_q   <= core_done_i;
            if (pop) begin
                fl_a_q <= head_a;
                fl_b_q <= head_b;
            end
            if (capture) begin
                out_a_q   <= fl_a_q;
                out_b_q   <= fl_b_q;
                out_gcd_q <= core_gcd_i;
            end
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed bench for gcd_dispatch with a behavioural gcd core attached to the core port.
module tb_gcd_dispatch;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic          core_valid;
    logic [W-1:0]  core_a, core_b;
    logic          core_done = 1'b0;
    logic [W-1:0]  core_gcd = '0;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_a, out_b, out_gcd;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] got_a[$];
    logic [W-1:0] got_b[$];
    logic [W-1:0] got_g[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_a[$];
    int issue_cnt = 0;
    int spurious  = 0;
    int done_len  = 1;

    logic         cm_busy = 1'b0;
    int           cm_cnt = 0;
    int           done_left = 0;
    logic         avail = 1'b0;
    logic [W-1:0] cm_a = '0, cm_b = '0;

    gcd_dispatch #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i(clk), .reset_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
        .core_valid_o(core_valid), .core_a_o(core_a), .core_b_o(core_b),
        .core_done_i(core_done), .core_gcd_i(core_gcd),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_a_o(out_a), .out_b_o(out_b), .out_gcd_o(out_gcd), .count_o(count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Core model plus output monitor; runs just after each falling edge so inputs set
    // on the falling edge by the stimulus are already settled.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            cm_busy   = 1'b0;
            cm_cnt    = 0;
            done_left = 0;
            core_done = 1'b0;
            avail     = 1'b0;
        end else begin
            if (out_valid) begin
                if (!avail) spurious++;
                if (out_ready) begin
                    got_a.push_back(out_a);
                    got_b.push_back(out_b);
                    got_g.push_back(out_gcd);
                    avail = 1'b0;
                end
            end
            if (done_left > 0) begin
                done_left--;
                if (done_left == 0) core_done = 1'b0;
            end
            if (core_valid) begin
                issue_cnt++;
                cm_a    = core_a;
                cm_b    = core_b;
                cm_cnt  = 3;
                cm_busy = 1'b1;
            end else if (cm_busy) begin
                if (cm_cnt > 0) begin
                    cm_cnt--;
                end else begin
                    cm_busy   = 1'b0;
                    core_done = 1'b1;
                    core_gcd  = gcd_f(cm_a, cm_b);
                    done_left = done_len;
                    avail     = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n        = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (got_g.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("result_timeout", got_g.size(), n);
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_count"}, got_g.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_g.size(); i++) begin
            chk($sformatf("%s_gcd%0d", tag, i), got_g[i], exp_q[i]);
            chk($sformatf("%s_a%0d", tag, i), got_a[i], exp_a[i]);
        end
        got_a.delete();
        got_b.delete();
        got_g.delete();
        exp_q.delete();
        exp_a.delete();
    endtask

    initial begin
        int k;
        int base_issue;
        logic saw_full;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_core_a", core_a, 0);
        chk("rst_core_b", core_b, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_gcd", out_gcd, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single pair with cycle-exact issue timing.
        out_ready = 1'b1;
        push(8'd48, 8'd18);
        chk("t1_count_after_push", count, 1);
        chk("t1_no_fallthrough", core_valid, 0);
        @(negedge clk);
        chk("t1_issue_valid", core_valid, 1);
        chk("t1_issue_a", core_a, 48);
        chk("t1_issue_b", core_b, 18);
        @(negedge clk);
        chk("t1_pulse_one_cycle", core_valid, 0);
        chk("t1_core_a_zero", core_a, 0);
        wait_results(1);
        chk("t1_out_b", got_b[0], 18);
        exp_q.push_back(8'd6); exp_a.push_back(8'd48);
        check_results("t1");
        repeat (2) @(negedge clk);
        chk("t1_issue_cnt", issue_cnt, 1);
        chk("t1_count_end", count, 0);
        chk("t1_out_valid_end", out_valid, 0);

        // Ordering and backpressure.
        out_ready = 1'b0;
        push(8'd60, 8'd84);
        push(8'd17, 8'd23);
        push(8'd100, 8'd75);
        push(8'd128, 8'd64);
        push(8'd7, 8'd13);
        chk("t2_full_count", count, 4);
        chk("t2_full_ready", in_ready, 0);
        in_valid = 1'b1;
        in_a     = 8'd255;
        in_b     = 8'd255;
        repeat (10) @(negedge clk);
        chk("t2_hold_count", count, 4);
        chk("t2_hold_ready", in_ready, 0);
        chk("t2_hold_valid", out_valid, 1);
        chk("t2_hold_gcd", out_gcd, 12);
        repeat (3) @(negedge clk);
        chk("t2_stable_a", out_a, 60);
        chk("t2_stable_b", out_b, 84);
        chk("t2_no_handshake", got_g.size(), 0);
        out_ready = 1'b1;
        k         = 0;
        saw_full  = 1'b0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            if (core_valid && count == 4 && !in_ready) saw_full = 1'b1;
            k++;
        end
        chk("t2_full_issue_refuses", saw_full, 1);
        chk("t2_accept_after_hs", got_g.size(), 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_results(6);
        exp_q = '{8'd12, 8'd1, 8'd25, 8'd64, 8'd1, 8'd255};
        exp_a = '{8'd60, 8'd17, 8'd100, 8'd128, 8'd7, 8'd255};
        check_results("t2");
        repeat (3) @(negedge clk);
        chk("t2_count_end", count, 0);

        // Push/pop collision with count 3 during ISSUE.
        out_ready = 1'b0;
        push(8'd1, 8'd1);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        push(8'd2, 8'd4);
        push(8'd3, 8'd9);
        push(8'd5, 8'd10);
        chk("t6_count3", count, 3);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_issue", core_valid, 1);
        chk("t6_issue_count", count, 3);
        chk("t6_issue_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a     = 8'd6;
        in_b     = 8'd8;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_collision_count", count, 3);
        chk("t6_collision_ready", in_ready, 1);
        wait_results(5);
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd2};
        exp_a = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6};
        check_results("t6");

        // Boundary operands.
        push(8'd0, 8'd5);
        push(8'd0, 8'd0);
        wait_results(2);
        chk("t3_b0", got_b[0], 5);
        chk("t3_b1", got_b[1], 0);
        exp_q = '{8'd5, 8'd0};
        exp_a = '{8'd0, 8'd0};
        check_results("t3");

        // Sticky done held for five cycles.
        repeat (3) @(negedge clk);
        done_len   = 5;
        base_issue = issue_cnt;
        push(8'd12, 8'd8);
        push(8'd9, 8'd6);
        wait_results(2);
        repeat (10) @(negedge clk);
        chk("t4_spurious", spurious, 0);
        chk("t4_issues", issue_cnt - base_issue, 2);
        exp_q = '{8'd4, 8'd3};
        exp_a = '{8'd12, 8'd9};
        check_results("t4");
        done_len = 1;
        repeat (8) @(negedge clk);

        // Reset while an operation is in flight with two entries queued.
        push(8'd10, 8'd4);
        push(8'd14, 8'd21);
        push(8'd30, 8'd12);
        chk("t5_pre_count", count, 2);
        chk("t5_pre_out_gcd", out_gcd, 3);
        rst = 1'b1;
        #2;
        chk("t5_rst_core_valid", core_valid, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_out_a", out_a, 0);
        chk("t5_rst_out_b", out_b, 0);
        chk("t5_rst_out_gcd", out_gcd, 0);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_ready", in_ready, 1);
        @(negedge clk);
        rst        = 1'b0;
        base_issue = issue_cnt;
        repeat (20) @(negedge clk);
        chk("t5_no_output", got_g.size(), 0);
        chk("t5_no_issue", issue_cnt - base_issue, 0);
        chk("t5_idle_count", count, 0);
        push(8'd48, 8'd18);
        wait_results(1);
        exp_q.push_back(8'd6); exp_a.push_back(8'd48);
        check_results("t5");
        chk("t5_spurious_total", spurious, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
